// File: rtl/au_pkg.sv
// Shared types and constants for the AU sequencer: request opcodes, AU opcodes,
// sequencer states and the fixed divide-by-zero result.
package au_pkg;

    typedef enum logic [2:0] {
        REQ_PASS = 3'd0,
        REQ_ADD  = 3'd1,
        REQ_SUB  = 3'd2,
        REQ_MUL  = 3'd3,
        REQ_DIV  = 3'd4
    } req_op_e;

    localparam logic [3:0] AU_OP_PASS = 4'h0;
    localparam logic [3:0] AU_OP_ADD  = 4'h1;
    localparam logic [3:0] AU_OP_SUB  = 4'h2;
    localparam logic [3:0] AU_OP_MUL  = 4'h4;
    localparam logic [3:0] AU_OP_DIV  = 4'h8;

    localparam logic [15:0] DIV_BY_ZERO_RES = 16'hFFFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_SETTLE_A,
        ST_LOAD_B,
        ST_SETTLE_B,
        ST_EXEC,
        ST_START,
        ST_WAIT,
        ST_RESP
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= REQ_DIV;
    endfunction

    function automatic logic [3:0] au_op_code(input logic [2:0] op);
        case (op)
            REQ_PASS: return AU_OP_PASS;
            REQ_ADD:  return AU_OP_ADD;
            REQ_SUB:  return AU_OP_SUB;
            REQ_MUL:  return AU_OP_MUL;
            REQ_DIV:  return AU_OP_DIV;
            default:  return AU_OP_PASS;
        endcase
    endfunction

endpackage

// File: rtl/au_sequencer_if.sv
// Request/response handshake bundle between a client and the AU sequencer.
interface au_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [7:0]  req_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_ovr;
    logic        res_zero;
    logic        res_err;

    modport master (
        output req_valid, req_op, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_ovr, res_zero, res_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_ovr, res_zero, res_err
    );
endinterface

// File: rtl/au_wait_counter.sv
// Loadable down-counter timing EXEC/WAIT phases; zero flags the capture cycle.
module au_wait_counter #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (CLR) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/au_sequencer.sv
// Sequences one AU operation at a time: loads A then B through the shared X bus,
// starts MUL/DIV, waits the completion time and holds the captured result.
module au_sequencer
    import au_pkg::*;
#(
    parameter int MUL_CYCLES  = 10,
    parameter int DIV_CYCLES  = 10,
    parameter int EXEC_CYCLES = 1
) (
    input  logic          CLK,
    input  logic          CLR,
    au_sequencer_if.slave bus,
    output logic [15:0]   X,
    output logic          LdA,
    output logic          LdB,
    output logic          START_MUL,
    output logic          START_DIV,
    output logic [3:0]    OP,
    input  logic [15:0]   Rout,
    input  logic          OVR,
    input  logic          ZERO
);

    localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES)
                           ? ((MUL_CYCLES > EXEC_CYCLES) ? MUL_CYCLES : EXEC_CYCLES)
                           : ((DIV_CYCLES > EXEC_CYCLES) ? DIV_CYCLES : EXEC_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] EXEC_LD = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] MUL_LD  = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] res_data_q, res_data_d;
    logic        res_ovr_q, res_ovr_d;
    logic        res_zero_q, res_zero_d;
    logic        res_err_q, res_err_d;

    logic             req_ready, res_valid;
    logic             cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;
    logic             is_long;

    assign is_long = (op_q == REQ_MUL) || (op_q == REQ_DIV);

    au_wait_counter #(.W(CNT_W)) u_cnt (
        .CLK      (CLK),
        .CLR      (CLR),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        res_data_d   = res_data_q;
        res_ovr_d    = res_ovr_q;
        res_zero_d   = res_zero_q;
        res_err_d    = res_err_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        req_ready    = 1'b0;
        res_valid    = 1'b0;
        X            = 16'h0000;
        LdA          = 1'b0;
        LdB          = 1'b0;
        START_MUL    = 1'b0;
        START_DIV    = 1'b0;
        OP           = AU_OP_PASS;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    op_d = bus.req_op;
                    a_d  = bus.req_a;
                    b_d  = bus.req_b;
                    // Rejected requests answer immediately and never touch the AU.
                    if (!op_legal(bus.req_op) || (bus.req_op == REQ_DIV && bus.req_b == 8'h00)) begin
                        state_d    = ST_RESP;
                        res_data_d = op_legal(bus.req_op) ? DIV_BY_ZERO_RES : 16'h0000;
                        res_ovr_d  = 1'b0;
                        res_zero_d = 1'b0;
                        res_err_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD_A;
                    end
                end
            end
            ST_LOAD_A: begin
                X       = a_q;
                LdA     = 1'b1;
                OP      = au_op_code(op_q);
                state_d = ST_SETTLE_A;
            end
            ST_SETTLE_A: begin
                X       = a_q;
                OP      = au_op_code(op_q);
                state_d = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                X       = {8'h00, b_q};
                LdB     = 1'b1;
                OP      = au_op_code(op_q);
                state_d = ST_SETTLE_B;
            end
            ST_SETTLE_B: begin
                X  = {8'h00, b_q};
                OP = au_op_code(op_q);
                if (is_long) begin
                    state_d = ST_START;
                end else begin
                    state_d      = ST_EXEC;
                    cnt_load     = 1'b1;
                    cnt_load_val = EXEC_LD;
                end
            end
            ST_START: begin
                X            = a_q;
                OP           = au_op_code(op_q);
                START_MUL    = (op_q == REQ_MUL);
                START_DIV    = (op_q == REQ_DIV);
                cnt_load     = 1'b1;
                cnt_load_val = (op_q == REQ_MUL) ? MUL_LD : DIV_LD;
                state_d      = ST_WAIT;
            end
            ST_EXEC, ST_WAIT: begin
                // X keeps A so a PASS operation returns it.
                X  = a_q;
                OP = au_op_code(op_q);
                if (cnt_zero) begin
                    res_data_d = Rout;
                    res_ovr_d  = OVR;
                    res_zero_d = ZERO;
                    res_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_RESP: begin
                res_valid = 1'b1;
                if (bus.res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q    <= ST_IDLE;
            op_q       <= 3'd0;
            a_q        <= 16'h0000;
            b_q        <= 8'h00;
            res_data_q <= 16'h0000;
            res_ovr_q  <= 1'b0;
            res_zero_q <= 1'b0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            res_data_q <= res_data_d;
            res_ovr_q  <= res_ovr_d;
            res_zero_q <= res_zero_d;
            res_err_q  <= res_err_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_data_q;
    assign bus.res_ovr   = res_ovr_q;
    assign bus.res_zero  = res_zero_q;
    assign bus.res_err   = res_err_q;

endmodule

// File: doc/au_sequencer.md
# au_sequencer

- Issues one arithmetic operation at a time to the AU datapath through a valid/ready request port.
- Per operation it:
  - drives the AU operand bus and load strobes;
  - pulses the multiply or divide start;
  - waits a parameterised completion time;
  - captures Rout/OVR/ZERO into a result register presented on a valid/ready response port.
- Sits directly upstream of the AU and owns all of its control inputs.

## Interface
Parameters:
- MUL_CYCLES, 10: WAIT cycles after START_MUL before capture (≥1).
- DIV_CYCLES, 10: WAIT cycles after START_DIV before capture (≥1).
- EXEC_CYCLES, 1: EXEC cycles for PASS/ADD/SUB before capture (≥1).

Ports:
- CLK  in  1  single clock, rising edge.
- CLR  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  3  0 PASS, 1 ADD, 2 SUB, 3 MUL, 4 DIV; 5–7 illegal.
- req_a  in  16  operand A (dividend; only [7:0] used by ADD/SUB/MUL).
- req_b  in  8  operand B.
- res_valid  out  1  result held.
- res_ready  in  1  result consumed.
- res_data  out  16  captured Rout (DIV: quotient[15:8], remainder[7:0]).
- res_ovr  out  1  captured OVR.
- res_zero  out  1  captured ZERO.
- res_err  out  1  illegal opcode or divide-by-zero.
- X  out  16  AU operand bus.
- LdA, LdB  out  1  AU load strobes; the AU captures on the falling edge.
- START_MUL, START_DIV  out  1  AU start pulses.
- OP  out  4  AU opcode: PASS 4'h0, ADD 4'h1, SUB 4'h2, MUL 4'h4, DIV 4'h8.
- Rout  in  16  AU result.
- OVR, ZERO  in  1  AU flags.

## Operation
- Request accept: req_valid & req_ready at a rising edge registers op, A and B.
- Illegal op:
  - goes directly to RESP with res_err=1 and res_data=16'h0000;
  - res_ovr=0, res_zero=0;
  - no AU strobes are driven.
- DIV with B==0: same as illegal op, except res_data=16'hFFFF; the AU is untouched.
- States:
  - IDLE → LOAD_A → SETTLE_A → LOAD_B → SETTLE_B.
  - From SETTLE_B: EXEC (PASS/ADD/SUB), or START → WAIT (MUL/DIV).
  - Then RESP → IDLE.
- LOAD_A: X=A, LdA=1.
- SETTLE_A: X=A, LdA=0. The falling edge of LdA captures A while X is still stable.
- LOAD_B: X={8'h00,B}, LdB=1.
- SETTLE_B: X={8'h00,B}, LdB=0.
- EXEC, START, WAIT: X=A, so PASS returns A.
- START: exactly one cycle with START_MUL=1 (MUL) or START_DIV=1 (DIV).
- EXEC/WAIT counter:
  - loads EXEC_CYCLES, MUL_CYCLES or DIV_CYCLES minus 1 on entry;
  - decrements each cycle.
  - In the cycle it reads 0, the rising edge registers Rout/OVR/ZERO into res_* and moves to RESP.
- Counter width: $clog2(max(MUL_CYCLES,DIV_CYCLES,EXEC_CYCLES)+1).
- OP is driven from the registered op from LOAD_A through the last EXEC/WAIT cycle. OP is 4'h0 in IDLE and RESP.
- RESP:
  - res_valid=1; res_* held stable until res_ready.
  - The handshake edge returns to IDLE and clears res_valid.
- Outputs when not in the states listed above: X=0, LdA=LdB=START_MUL=START_DIV=0.

## Timing
- Reset (CLR=1 at an edge):
  - state=IDLE; all registered outputs 0;
  - req_ready=1 in the following cycle.
- CLR mid-operation: abandons the operation and drops any strobe at that edge. The AU keeps stale operands; that is harmless because the next op reloads them.
- Cycle numbering: acceptance edge ends cycle 0. LOAD_A=1, SETTLE_A=2, LOAD_B=3, SETTLE_B=4.
- PASS/ADD/SUB: EXEC in cycles 5..4+EXEC_CYCLES; res_valid from cycle 5+EXEC_CYCLES (6 at default).
- MUL/DIV: START in cycle 5; WAIT in cycles 6..5+N; res_valid from cycle 6+N (16 at default).
- Error response: res_valid from cycle 1.
- req_ready=0 from cycle 1 until the cycle after the response handshake.
- Back-to-back: a response handshake in cycle k allows a new acceptance in cycle k+1, giving a minimum of one idle cycle.
- res_ready held high while entering RESP: handshake completes in the first RESP cycle.
- req_valid is ignored outside IDLE; no queueing.

## Structure
- Package au_pkg holds:
  - req_op enum and the AU OP constants (4'h0/1/2/4/8);
  - state enum;
  - the DIV_BY_ZERO result constant 16'hFFFF.
- One sub-module, au_wait_counter:
  - loadable down-counter with a zero flag;
  - parameterised width;
  - synchronous CLR.

## Test plan
- ADD A=16'h0050, B=8'h30 → res_valid at cycle 6, res_data=AU Rout (16'h0080), res_err=0. Also check LdA high only in cycle 1, LdB only in cycle 3, and X stable across each falling strobe.
- MUL A=8'h0C, B=8'h0B → START_MUL high only in cycle 5; res_valid at cycle 16; res_data=16'h0084.
- DIV A=16'h0064, B=8'h07 → res_data=16'h0E02 at cycle 16. DIV B=0 → res_valid at cycle 1, res_data=16'hFFFF, res_err=1, and no strobes.
- Illegal req_op=6 → res_err=1, res_data=0, and OP stays 0 throughout.
- res_ready held low for 5 cycles → res_* stable and req_ready=0. Then release and issue a new request the next cycle → accepted.
- CLR asserted during WAIT of MUL → next cycle IDLE with all outputs 0; a following SUB completes normally.
